// File: rtl/seq_mult_16bit.sv
// Sequential unsigned WIDTHxWIDTH shift-and-add multiplier driving an external ripple-carry adder.
// Latency: done pulses 16 edges after the accepting edge; busy is high for the 16 iteration cycles.
// Backpressure: start is taken only in IDLE or DONE; a start arriving during RUN is ignored.
module seq_mult_16bit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Count value seen on the final iteration edge.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic [CNT_W-1:0]   count;
  logic               accept;
  logic               last;
  logic [2*WIDTH-1:0] shifted;

  // The 33-bit {cout, sum, P_lo} shifted right by one; cout must be kept,
  // otherwise large operands lose their top partial-sum bit.
  assign shifted = {add_cout, add_sum, p_lo[WIDTH-1:1]};

  // Adder operands come from registers only, so no input-to-output path exists.
  assign add_a   = p_hi;
  assign add_b   = p_lo[0] ? m : '0;
  assign add_cin = 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus Moore status outputs and datapath controls.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count == LAST_CNT) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // A start here reloads immediately, giving back-to-back operation.
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, one shift-and-add step per RUN edge, and result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      m       <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      count   <= '0;
      product <= '0;
    end else if (accept) begin
      m     <= multiplicand;
      p_hi  <= '0;
      p_lo  <= multiplier;
      count <= '0;
    end else if (busy) begin
      {p_hi, p_lo} <= shifted;
      count        <= count + 1'b1;
      // product only moves on the final iteration, so it holds steady
      // while busy and across IDLE.
      if (last) begin
        product <= shifted;
      end
    end
  end

endmodule
